regfile_scheduler: RTL and testbench

Write-port scheduler and hazard scoreboard for the 32x32 register file (x0 hardwired to zero, single write port, two registered read ports). It shares the one write port between two writeback requesters (requester 0: ALU, requester 1: load unit) using round-robin arbitration. It tracks which destination registers have a write outstanding and stalls issue on RAW/WAW hazards. It sits between the issue stage, the writeback sources and the register file's we/rd/wd inputs.

---
 rtl/regfile_scheduler.sv | 99 +++++++++
 tb/tb_regfile_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scheduler.sv
// Write-port scheduler for the 32x32 register file: round-robin arbitration of two
// writeback sources onto the single write port, plus a RAW/WAW hazard scoreboard.
module regfile_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rs1,
    input  logic [4:0]  iss_rs2,
    input  logic [4:0]  iss_rd,
    output logic        iss_stall,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_rd,
    input  logic [31:0] wb0_data,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_rd,
    input  logic [31:0] wb1_data,
    output logic        wb0_ready,
    output logic        wb1_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd,
    output logic [31:0] pending
);

    logic [31:0] r_pending;
    logic        r_rr_ptr;
    logic        r_rf_we_p1;
    logic [4:0]  r_rf_rd_p1;
    logic [31:0] r_rf_wd_p1;

    logic        w_hazard;
    logic        w_reserve;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_xfer;
    logic [4:0]  w_sel_rd;
    logic [31:0] w_sel_data;
    logic [31:0] w_pend_nxt;

    // x0 never blocks issue, so its operand slots are masked explicitly.
    assign w_hazard  = ((iss_rs1 != 5'd0) && r_pending[iss_rs1])
                     || ((iss_rs2 != 5'd0) && r_pending[iss_rs2])
                     || ((iss_rd  != 5'd0) && r_pending[iss_rd]);
    assign iss_stall = iss_valid && w_hazard;
    assign w_reserve = iss_valid && !w_hazard && (iss_rd != 5'd0);

    assign w_gnt0     = wb0_valid && (!wb1_valid || !r_rr_ptr);
    assign w_gnt1     = wb1_valid && (!wb0_valid ||  r_rr_ptr);
    assign w_xfer     = w_gnt0 || w_gnt1;
    assign w_sel_rd   = w_gnt1 ? wb1_rd   : wb0_rd;
    assign w_sel_data = w_gnt1 ? wb1_data : wb0_data;

    // Release of the committing register is applied first so a same-cycle reservation wins.
    always_comb begin
        w_pend_nxt = r_pending;
        if (r_rf_we_p1) begin
            w_pend_nxt[r_rf_rd_p1] = 1'b0;
        end
        if (w_reserve) begin
            w_pend_nxt[iss_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 32'd0;
            r_rr_ptr  <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            if (w_xfer) begin
                r_rr_ptr <= w_gnt0;
            end
        end
    end

    // Commit stage: the regfile write happens one cycle after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we_p1 <= 1'b0;
            r_rf_rd_p1 <= 5'd0;
            r_rf_wd_p1 <= 32'd0;
        end else if (w_xfer) begin
            r_rf_we_p1 <= (w_sel_rd != 5'd0);
            r_rf_rd_p1 <= w_sel_rd;
            r_rf_wd_p1 <= w_sel_data;
        end else begin
            r_rf_we_p1 <= 1'b0;
        end
    end

    assign wb0_ready = w_gnt0;
    assign wb1_ready = w_gnt1;
    assign rf_we     = r_rf_we_p1;
    assign rf_rd     = r_rf_rd_p1;
    assign rf_wd     = r_rf_wd_p1;
    assign pending   = r_pending;

endmodule

// File: tb/tb_regfile_scheduler.sv
// Bench for regfile_scheduler: table of per-cycle vectors with hand-derived stall/grant
// expectations, a commit scoreboard queue and a pending-bitmap model.
module tb_regfile_scheduler;

    logic        clk;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_stall;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_ready, wb1_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [31:0] pending;

    regfile_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_stall (iss_stall),
        .wb0_valid (wb0_valid),
        .wb0_rd    (wb0_rd),
        .wb0_data  (wb0_data),
        .wb1_valid (wb1_valid),
        .wb1_rd    (wb1_rd),
        .wb1_data  (wb1_data),
        .wb0_ready (wb0_ready),
        .wb1_ready (wb1_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wd     (rf_wd),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs1, rs2, rd;
        logic        w0v;
        logic [4:0]  w0rd;
        logic [31:0] w0d;
        logic        w1v;
        logic [4:0]  w1rd;
        logic [31:0] w1d;
        logic        e_stall, e_r0, e_r1;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } cmt_t;

    vec_t tbl[$];
    cmt_t exp_q[$];

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;

    function automatic vec_t mk(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd,
                                input logic w0v, input logic [4:0] w0rd, input logic [31:0] w0d,
                                input logic w1v, input logic [4:0] w1rd, input logic [31:0] w1d,
                                input logic e_stall, input logic e_r0, input logic e_r1);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.w0v = w0v; v.w0rd = w0rd; v.w0d = w0d;
        v.w1v = w1v; v.w1rd = w1rd; v.w1d = w1d;
        v.e_stall = e_stall; v.e_r0 = e_r0; v.e_r1 = e_r1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        iss_valid = 1'b0; iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd0;
        wb0_valid = 1'b0; wb0_rd = 5'd0; wb0_data = 32'd0;
        wb1_valid = 1'b0; wb1_rd = 5'd0; wb1_data = 32'd0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        cmt_t        c;
        logic [31:0] nxt;
        string       tag;
        iss_valid = v.iv; iss_rs1 = v.rs1; iss_rs2 = v.rs2; iss_rd = v.rd;
        wb0_valid = v.w0v; wb0_rd = v.w0rd; wb0_data = v.w0d;
        wb1_valid = v.w1v; wb1_rd = v.w1rd; wb1_data = v.w1d;
        #2;
        tag = $sformatf("v%0d", idx);
        check({tag, " iss_stall"}, {31'd0, iss_stall}, {31'd0, v.e_stall});
        check({tag, " wb0_ready"}, {31'd0, wb0_ready}, {31'd0, v.e_r0});
        check({tag, " wb1_ready"}, {31'd0, wb1_ready}, {31'd0, v.e_r1});
        if (v.e_r0) begin
            c.we = (v.w0rd != 5'd0); c.rd = v.w0rd; c.wd = v.w0d;
        end else if (v.e_r1) begin
            c.we = (v.w1rd != 5'd0); c.rd = v.w1rd; c.wd = v.w1d;
        end else begin
            c.we = 1'b0; c.rd = m_rd; c.wd = m_wd;
        end
        exp_q.push_back(c);
        nxt = m_pend;
        if (m_we) nxt[m_rd] = 1'b0;
        if (v.iv && !v.e_stall && (v.rd != 5'd0)) nxt[v.rd] = 1'b1;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            c = exp_q.pop_front();
            check({tag, " rf_we"}, {31'd0, rf_we}, {31'd0, c.we});
            check({tag, " rf_rd"}, {27'd0, rf_rd}, {27'd0, c.rd});
            check({tag, " rf_wd"}, rf_wd, c.wd);
            m_we = c.we; m_rd = c.rd; m_wd = c.wd;
        end
        m_pend = nxt;
        check({tag, " pending"}, pending, m_pend);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        rst_n = 1'b0;
        m_pend = 32'd0; m_we = 1'b0; m_rd = 5'd0; m_wd = 32'd0;

        //       iv rs1   rs2   rd     w0v w0rd   w0d            w1v w1rd   w1d            st r0 r1
        tbl.push_back(mk(1, 5'd0, 5'd0, 5'd5,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 5'd5, 5'd0, 5'd0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 0));
        tbl.push_back(mk(1, 5'd5, 5'd0, 5'd0,  0, 5'd0,  32'h0,        1, 5'd5,  32'hDEADBEEF, 1, 0, 1));
        tbl.push_back(mk(1, 5'd5, 5'd0, 5'd0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 0));
        tbl.push_back(mk(1, 5'd5, 5'd0, 5'd0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  1, 5'd10, 32'hA0,       1, 5'd11, 32'hB1,       0, 1, 0));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  1, 5'd12, 32'hA2,       1, 5'd11, 32'hB1,       0, 0, 1));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  1, 5'd12, 32'hA2,       1, 5'd13, 32'hB3,       0, 1, 0));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  1, 5'd14, 32'hA4,       1, 5'd13, 32'hB3,       0, 0, 1));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0,  1, 5'd0,  32'h1234,     0, 5'd0,  32'h0,        0, 1, 0));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  1, 5'd20, 32'hC0,       1, 5'd21, 32'hC1,       0, 0, 1));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  1, 5'd20, 32'hC0,       0, 5'd0,  32'h0,        0, 1, 0));
        tbl.push_back(mk(1, 5'd0, 5'd0, 5'd7,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 5'd0, 5'd0, 5'd7,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 0));
        tbl.push_back(mk(1, 5'd0, 5'd0, 5'd7,  1, 5'd7,  32'h77,       0, 5'd0,  32'h0,        1, 1, 0));
        tbl.push_back(mk(1, 5'd0, 5'd0, 5'd7,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 0));
        tbl.push_back(mk(1, 5'd0, 5'd0, 5'd7,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       0, 0, 1));
        tbl.push_back(mk(1, 5'd0, 5'd0, 5'd9,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 5'd0, 5'd9, 5'd0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 0, 0));
        tbl.push_back(mk(1, 5'd0, 5'd0, 5'd0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 5'd0, 5'd0, 5'd0,  1, 5'd3,  32'h33,       1, 5'd4,  32'h44,       0, 1, 0));

        repeat (2) @(posedge clk);
        #1;
        check("reset rf_we", {31'd0, rf_we}, 32'd0);
        check("reset rf_rd", {27'd0, rf_rd}, 32'd0);
        check("reset rf_wd", rf_wd, 32'd0);
        check("reset pending", pending, 32'd0);
        check("reset iss_stall", {31'd0, iss_stall}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
        end

        // Mid-stream reset while x3 is on the write port and x4 is still waiting.
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("midreset rf_we", {31'd0, rf_we}, 32'd0);
        check("midreset rf_rd", {27'd0, rf_rd}, 32'd0);
        check("midreset rf_wd", rf_wd, 32'd0);
        check("midreset pending", pending, 32'd0);
        @(posedge clk);
        #1;
        check("midreset hold rf_we", {31'd0, rf_we}, 32'd0);
        rst_n = 1'b1;
        m_pend = 32'd0; m_we = 1'b0; m_rd = 5'd0; m_wd = 32'd0;
        exp_q.delete();

        run_vec(mk(0, 5'd0, 5'd0, 5'd0, 1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 1, 0), 100);
        run_vec(mk(0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,  1, 5'd4, 32'h44, 0, 0, 1), 101);
        run_vec(mk(0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0, 0), 102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
